clb_adder_chain_pipe: RTL
=========================

CLB_ADDER_CHAIN_PIPE -- requirements
Module: clb_adder_chain_pipe

Interface
REQ-001 SHALL have parameter WIDTH, 16, operand/result width in bits (>=2).
REQ-002 SHALL have parameter SEG, 4, bits per pipeline segment; WIDTH%SEG!=0 SHALL be an elaboration error.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  operand beat offered.
REQ-006 in_ready  out  1  block accepts beat this cycle.
REQ-007 a, b  in  WIDTH each  operands.
REQ-008 cin  in  1  carry-in (ignored for subtract).
REQ-009 op  in  2  00 add, 01 subtract, 10 add-no-carry, 11 treated as 00.
REQ-010 out_valid  out  1  result beat present.
REQ-011 out_ready  in  1  downstream accepts result.
REQ-012 sum  out  WIDTH  result; cout out 1 carry-out (subtract: 1 = no borrow); ovf out 1 signed overflow.

Function
REQ-013 Beat accepted when in_valid&&in_ready; result leaves when out_valid&&out_ready.
REQ-014 STAGES=WIDTH/SEG; segment k SHALL add bits [k*SEG+SEG-1:k*SEG] in pipeline stage k, registering partial sum, carry and the remaining upper operand bits.
REQ-015 Latency: beat accepted at edge N SHALL appear on out_valid after edge N+STAGES-1 when no stall occurs.
REQ-016 Subtract SHALL compute a + ~b + 1; add SHALL use cin; add-no-carry SHALL force carry-in 0.
REQ-017 Arithmetic modulo 2^WIDTH; cout = carry out of MSB; ovf = carry into MSB XOR carry out of MSB.
REQ-018 Stall = out_valid && !out_ready; during stall every stage register SHALL hold and in_ready SHALL be 0.
REQ-019 in_ready = !stall (combinational); bubbles are not compressed.
REQ-020 Results SHALL leave in acceptance order; no beat dropped or duplicated.
REQ-021 Back-to-back accepts SHALL sustain one result per cycle when out_ready stays high.
REQ-022 sum/cout/ovf SHALL hold stable while out_valid && !out_ready.

Reset
REQ-023 reset SHALL clear all stage valids, sum, cout, ovf (and acc if present) to 0 on the next edge, discarding in-flight beats.
REQ-024 in_valid during reset SHALL be ignored; in_ready SHALL read 1 while reset is asserted.

Configuration
REQ-025 Macro CLB_ADDER_CHAIN_ACC_EN defined: ports acc_clr (in 1) and acc (out WIDTH) exist; on each output handshake acc <= acc_clr ? sum : acc + sum (modulo 2^WIDTH).
REQ-026 Macro undefined: acc_clr/acc ports and accumulator logic SHALL be absent; all other behaviour identical.

Structure
REQ-027 Package clb_adder_chain_pkg SHALL hold op encoding constants (OP_ADD, OP_SUB, OP_ADDNC) and the 2-bit op typedef.
REQ-028 Sub-module clb_adder_chain_seg SHALL implement one SEG-bit ripple segment (combinational, per-bit full-adder chain); parent instantiates STAGES copies plus pipeline registers.

Verification (WIDTH=16, SEG=4, latency 4)
REQ-029 add a=0x1234 b=0x0001 cin=0 -> 4 cycles later sum=0x1235 cout=0 ovf=0.
REQ-030 add a=0xFFFF b=0x0001 cin=0 -> sum=0x0000 cout=1 ovf=0; add a=0x7FFF b=0x0001 -> sum=0x8000 cout=0 ovf=1.
REQ-031 sub a=0x0005 b=0x0007 -> sum=0xFFFE cout=0; op=10 a=0x0001 b=0x0001 cin=1 -> sum=0x0002.
REQ-032 6 back-to-back beats, out_ready low cycles 5-7 -> in_ready low during stall, all 6 results in order, none lost.
REQ-033 reset asserted with 3 beats in flight -> next cycle out_valid=0, sum=0, no stale beat emerges afterward.
REQ-034 ACC_EN build: sums 3, 4, 5 with acc_clr=1 on first -> acc = 3, 7, 12.

Source files
------------

// File: rtl/clb_adder_chain_pkg.sv
// clb_adder_chain_pkg: op encoding shared by the pipelined adder chain and its users.
package clb_adder_chain_pkg;
    typedef logic [1:0] op_t;
    localparam op_t OP_ADD   = 2'b00;
    localparam op_t OP_SUB   = 2'b01;
    localparam op_t OP_ADDNC = 2'b10;
endpackage

// File: rtl/clb_adder_chain_seg.sv
// clb_adder_chain_seg: SEG-bit ripple-carry segment built from a per-bit full-adder chain.
module clb_adder_chain_seg
    import clb_adder_chain_pkg::*;
#(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);
    logic [SEG:0] c;
    always_comb begin
        c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end
    assign co = c[SEG];
endmodule

// File: rtl/clb_adder_chain_pipe.sv
// clb_adder_chain_pipe: WIDTH-bit add/subtract pipelined as WIDTH/SEG ripple segments, one per stage.
// Defining CLB_ADDER_CHAIN_ACC_EN adds an accumulator (acc_clr/acc) updated on each output handshake.
module clb_adder_chain_pipe
    import clb_adder_chain_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  op_t              op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef CLB_ADDER_CHAIN_ACC_EN
    ,
    input  logic             acc_clr,
    output logic [WIDTH-1:0] acc
`endif
);
    localparam int STAGES = WIDTH / SEG;

    if (WIDTH < 2 || WIDTH % SEG != 0) begin : g_bad_cfg
        $error("clb_adder_chain_pipe: WIDTH must be >= 2 and a multiple of SEG");
    end

    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             v_q   [STAGES];
    logic             c_q   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic [SEG-1:0]   seg_s [STAGES];
    logic             seg_c [STAGES];

    assign stall    = out_valid && !out_ready;
    assign in_ready = reset || !stall;
    assign b_eff    = (op == OP_SUB) ? ~b : b;
    assign c0       = (op == OP_SUB) ? 1'b1 : (op == OP_ADDNC) ? 1'b0 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        if (k == 0) begin : g_head
            clb_adder_chain_seg #(.SEG(SEG)) u_seg (
                .a(a[SEG-1:0]), .b(b_eff[SEG-1:0]), .ci(c0), .s(seg_s[0]), .co(seg_c[0])
            );
        end else begin : g_tail
            clb_adder_chain_seg #(.SEG(SEG)) u_seg (
                .a(a_q[k-1][k*SEG +: SEG]), .b(b_q[k-1][k*SEG +: SEG]), .ci(c_q[k-1]),
                .s(seg_s[k]), .co(seg_c[k])
            );
        end
    end

    // Operands travel with the beat so each stage sees its own slice; the whole pipe freezes on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (!stall) begin
            v_q[0] <= in_valid;
            c_q[0] <= seg_c[0];
            a_q[0] <= a;
            b_q[0] <= b_eff;
            s_q[0] <= WIDTH'(seg_s[0]);
            for (int k = 1; k < STAGES; k++) begin
                v_q[k] <= v_q[k-1];
                c_q[k] <= seg_c[k];
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
                s_q[k] <= s_q[k-1] | (WIDTH'(seg_s[k]) << (k * SEG));
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    // Carry into the MSB is recovered from the MSB's own operand and sum bits.
    assign ovf       = a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1] ^ sum[WIDTH-1] ^ cout;

`ifdef CLB_ADDER_CHAIN_ACC_EN
    always_ff @(posedge clk) begin
        if (reset) acc <= '0;
        else if (out_valid && out_ready) acc <= acc_clr ? sum : acc + sum;
    end
`endif
endmodule
